// File: rtl/rsu_boot_sequencer_if.sv
// Command/response channel between the CPU IO register block and the RSU boot sequencer.
//
// Signals
//   cmd_valid / cmd_ready     handshake; a command transfers when both are high
//   cmd_op     [1:0]          0 = read param, 1 = write param, 2 = boot, 3 = reserved
//   cmd_param  [2:0]          RSU parameter index (read/write only)
//   cmd_src    [1:0]          RSU read_source (read only)
//   cmd_data   [31:0]         write data; boot uses [29:0] as page address, [31:30] as wdt select
//   rsp_valid                 one-cycle pulse when a command finishes
//   rsp_err                   qualifies rsp_valid: timeout or reserved op
//   rsp_data   [31:0]         last read result, held until the next response
//
// Modports
//   master  CPU/IO side (drives commands, receives responses)
//   slave   sequencer side
interface rsu_boot_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_param;
  logic [1:0]  cmd_src;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_param, cmd_src, cmd_data,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_param, cmd_src, cmd_data,
    output cmd_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/rsu_boot_sequencer.sv
// Sequencer and single-owner front end for the remote-system-update (RSU) IP core.
// Takes one command at a time (read param, write param, boot image), generates the
// RSU IP strobes, waits for RSU busy to drop with a timeout and returns a response.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clk_en          clock enable; all state advances only when high
//   cmd             command/response channel (rsu_boot_sequencer_if.slave)
//   rsu_param       to IP param
//   rsu_src         to IP read_source
//   rsu_mosi        to IP data_in
//   rsu_rd          to IP read_param (one-cycle pulse)
//   rsu_wr          to IP write_param (one-cycle pulse)
//   rsu_reconfig    to IP reconfig (sticky until reset)
//   rsu_timer       to IP reset_timer
//   rsu_busy        from IP busy
//   rsu_miso        from IP data_out
//
// Build option
//   RSU_WDT_EN      when defined, boot also programs the watchdog value/enable params and
//                   rsu_timer kicks every CWdtKickDiv enabled cycles; otherwise the boot
//                   goes page write -> reconfig and rsu_timer is tied low.
module rsu_boot_sequencer #(
  parameter logic [2:0]  CPageParam   = 3'h4,
  parameter logic [2:0]  CWdtValParam = 3'h2,
  parameter logic [2:0]  CWdtEnParam  = 3'h3,
  parameter int unsigned CBusyTmo     = 1024,
  parameter int unsigned CWdtKickDiv  = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  rsu_boot_sequencer_if.slave cmd,
  output logic [2:0]  rsu_param,
  output logic [1:0]  rsu_src,
  output logic [31:0] rsu_mosi,
  output logic        rsu_rd,
  output logic        rsu_wr,
  output logic        rsu_reconfig,
  output logic        rsu_timer,
  input  logic        rsu_busy,
  input  logic [31:0] rsu_miso
);

  localparam int unsigned CntW = $clog2(CBusyTmo + 1);

  localparam logic [1:0] OpRd   = 2'd0;
  localparam logic [1:0] OpBoot = 2'd2;

  typedef enum logic [6:0] {
    StIdle     = 7'b0000001,
    StLoad     = 7'b0000010,
    StStrobe   = 7'b0000100,
    StGuard    = 7'b0001000,
    StWait     = 7'b0010000,
    StReconfig = 7'b0100000,
    StResp     = 7'b1000000
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [2:0]      param_q, param_d;
  logic [1:0]      src_q, src_d;
  logic [31:0]     mosi_q, mosi_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            guard_q, guard_d;
  logic            err_q, err_d;
  logic            init_q;
`ifdef RSU_WDT_EN
  logic [1:0]      step_q, step_d;
  logic            wdt_long_q, wdt_long_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    param_d = param_q;
    src_d   = src_q;
    mosi_d  = mosi_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    guard_d = guard_q;
    err_d   = err_q;
`ifdef RSU_WDT_EN
    step_d     = step_q;
    wdt_long_d = wdt_long_q;
`endif
    rsu_rd  = 1'b0;
    rsu_wr  = 1'b0;
    // Gated by clk_en so that a visible handshake always means the command was taken.
    cmd.cmd_ready = init_q && clk_en && (state_q == StIdle);

    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          op_d  = cmd.cmd_op;
          err_d = 1'b0;
          if (cmd.cmd_op == 2'd3) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (cmd.cmd_op == OpBoot) begin
            param_d = CPageParam;
            src_d   = 2'b00;
            mosi_d  = {2'b00, cmd.cmd_data[29:0]};
`ifdef RSU_WDT_EN
            step_d     = 2'd0;
            wdt_long_d = |cmd.cmd_data[31:30];
`endif
            state_d = StLoad;
          end else begin
            param_d = cmd.cmd_param;
            src_d   = cmd.cmd_src;
            mosi_d  = cmd.cmd_data;
            state_d = StLoad;
          end
        end
      end
      StLoad: state_d = StStrobe;
      StStrobe: begin
        rsu_rd  = (op_q == OpRd);
        rsu_wr  = (op_q != OpRd);
        cnt_d   = '0;
        guard_d = 1'b0;
        state_d = StGuard;
      end
      StGuard: begin
        // IP raises busy a couple of cycles late; ignore it here.
        cnt_d   = cnt_q + 1'b1;
        guard_d = 1'b1;
        if (guard_q) state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (!rsu_busy) begin
          if (op_q == OpRd) rdata_d = rsu_miso;
          if (op_q == OpBoot) begin
`ifdef RSU_WDT_EN
            unique case (step_q)
              2'd0: begin
                param_d = CWdtValParam;
                mosi_d  = wdt_long_q ? {20'hFFFFF, 12'h000} : 32'h0;
                step_d  = 2'd1;
                state_d = StLoad;
              end
              2'd1: begin
                param_d = CWdtEnParam;
                mosi_d  = 32'h1;
                step_d  = 2'd2;
                state_d = StLoad;
              end
              default: state_d = StReconfig;
            endcase
`else
            state_d = StReconfig;
`endif
          end else begin
            state_d = StResp;
          end
        end else if (cnt_q == CntW'(CBusyTmo - 1)) begin
          // Timeout aborts any boot step without touching reconfig.
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      // Device is reloading; only reset leaves this state.
      StReconfig: state_d = StReconfig;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      param_q <= 3'b000;
      src_q   <= 2'b00;
      mosi_q  <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
      guard_q <= 1'b0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      op_q    <= op_d;
      param_q <= param_d;
      src_q   <= src_d;
      mosi_q  <= mosi_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      err_q   <= err_d;
      init_q  <= 1'b1;
    end
  end

`ifdef RSU_WDT_EN
  localparam int unsigned KickW = (CWdtKickDiv > 1) ? $clog2(CWdtKickDiv) : 1;

  logic [KickW-1:0] kick_q;
  logic             timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q     <= 2'd0;
      wdt_long_q <= 1'b0;
      kick_q     <= '0;
      timer_q    <= 1'b0;
    end else if (clk_en) begin
      step_q     <= step_d;
      wdt_long_q <= wdt_long_d;
      kick_q     <= kick_q + 1'b1;
      timer_q    <= (kick_q == KickW'(CWdtKickDiv - 1)) && (state_d != StReconfig);
    end
  end

  assign rsu_timer = timer_q;
`else
  assign rsu_timer = 1'b0;
`endif

  assign rsu_param     = param_q;
  assign rsu_src       = src_q;
  assign rsu_mosi      = mosi_q;
  assign rsu_reconfig  = (state_q == StReconfig);
  assign cmd.rsp_valid = (state_q == StResp);
  assign cmd.rsp_err   = (state_q == StResp) && err_q;
  assign cmd.rsp_data  = rdata_q;

endmodule

// File: tb/tb_rsu_boot_sequencer.sv
// Directed bench for rsu_boot_sequencer. Cycle index n counts clock edges after the
// accept edge: n=0 Load, 1 Strobe, 2-3 Guard, 4 Wait, so a response with no busy is at n=5.
module tb_rsu_boot_sequencer;
  localparam int unsigned Tmo     = 16;
  localparam int unsigned KickDiv = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [2:0]  rsu_param;
  logic [1:0]  rsu_src;
  logic [31:0] rsu_mosi;
  logic        rsu_rd, rsu_wr, rsu_reconfig, rsu_timer;
  logic        rsu_busy = 1'b0;
  logic [31:0] rsu_miso = 32'h0;

  rsu_boot_sequencer_if bus ();

  rsu_boot_sequencer #(
    .CBusyTmo    (Tmo),
    .CWdtKickDiv (KickDiv)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .cmd          (bus.slave),
    .rsu_param    (rsu_param),
    .rsu_src      (rsu_src),
    .rsu_mosi     (rsu_mosi),
    .rsu_rd       (rsu_rd),
    .rsu_wr       (rsu_wr),
    .rsu_reconfig (rsu_reconfig),
    .rsu_timer    (rsu_timer),
    .rsu_busy     (rsu_busy),
    .rsu_miso     (rsu_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Results of the last run_cmd.
  int          lat;
  int          n_rd;
  logic [2:0]  rd_param;
  logic [1:0]  rd_src;
  logic [2:0]  wr_param[$];
  logic [31:0] wr_data[$];
  logic        saw_rsp, rsp_err_s, saw_reconfig;

  // Issues one command and runs a tiny IP model: after each strobe busy stays high through
  // the two guard cycles plus busy_len wait cycles. clk_en drops for frz_len cycles after
  // the sample at n == frz_at.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] prm, input logic [1:0] src,
                         input logic [31:0] data, input int busy_len, input int budget,
                         input int frz_at, input int frz_len);
    int rem;
    rem = 0;
    lat = -1;
    n_rd = 0;
    rd_param = '0;
    rd_src = '0;
    wr_param.delete();
    wr_data.delete();
    saw_rsp = 1'b0;
    rsp_err_s = 1'b0;
    saw_reconfig = 1'b0;
    rsu_busy = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_param = prm;
    bus.cmd_src = src;
    bus.cmd_data = data;
    for (int k = 0; k < 20 && !bus.cmd_ready; k++) step();
    check_eq("accept_ready", {31'h0, bus.cmd_ready}, 32'h1);
    step();
    bus.cmd_valid = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (n > 0) step();
      rsu_busy = (rem > 0);
      if (rem > 0) rem--;
      if (rsu_wr) begin
        wr_param.push_back(rsu_param);
        wr_data.push_back(rsu_mosi);
      end
      if (rsu_rd) begin
        n_rd++;
        rd_param = rsu_param;
        rd_src = rsu_src;
      end
      if (rsu_wr || rsu_rd) rem = 2 + busy_len;
      if (n == frz_at) clk_en = 1'b0;
      if (n == frz_at + frz_len) clk_en = 1'b1;
      if (bus.rsp_valid) begin
        lat = n;
        saw_rsp = 1'b1;
        rsp_err_s = bus.rsp_err;
        break;
      end
      if (rsu_reconfig) begin
        lat = n;
        saw_reconfig = 1'b1;
        break;
      end
    end
    clk_en = 1'b1;
    rsu_busy = 1'b0;
  endtask

  int cnt_a, cnt_b, cnt_c;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_param = 3'd0;
    bus.cmd_src = 2'd0;
    bus.cmd_data = 32'h0;

    // Reset state
    step();
    step();
    check_eq("rst_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check_eq("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("rst_reconfig", {31'h0, rsu_reconfig}, 32'h0);
    check_eq("rst_mosi", rsu_mosi, 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("first_cycle_ready", {31'h0, bus.cmd_ready}, 32'h0);
    step();
    check_eq("idle_ready", {31'h0, bus.cmd_ready}, 32'h1);

    // Write param 5 = 0x1234, busy held for three wait cycles -> response at n=8
    run_cmd(2'd1, 3'd5, 2'd0, 32'h0000_1234, 3, 40, -1, 0);
    check_eq("wr_count", wr_param.size(), 32'd1);
    check_eq("wr_param", {29'h0, wr_param[0]}, 32'd5);
    check_eq("wr_mosi", wr_data[0], 32'h0000_1234);
    check_eq("wr_no_rd", n_rd, 32'd0);
    check_eq("wr_latency", lat, 32'd8);
    check_eq("wr_err", {31'h0, rsp_err_s}, 32'h0);
    step();
    check_eq("wr_rsp_pulse", {31'h0, bus.rsp_valid}, 32'h0);

    // Read param 4 from source 2, no busy -> response at n=5
    rsu_miso = 32'h00AB_CDE0;
    run_cmd(2'd0, 3'd4, 2'd2, 32'h0, 0, 40, -1, 0);
    check_eq("rd_count", n_rd, 32'd1);
    check_eq("rd_param", {29'h0, rd_param}, 32'd4);
    check_eq("rd_src", {30'h0, rd_src}, 32'd2);
    check_eq("rd_no_wr", wr_param.size(), 32'd0);
    check_eq("rd_latency", lat, 32'd5);
    check_eq("rd_data", bus.rsp_data, 32'h00AB_CDE0);
    check_eq("rd_err", {31'h0, rsp_err_s}, 32'h0);
    rsu_miso = 32'hDEAD_BEEF;
    step();
    step();
    check_eq("rd_data_held", bus.rsp_data, 32'h00AB_CDE0);

    // Reserved op -> error response on the cycle right after accept, IP untouched
    run_cmd(2'd3, 3'd1, 2'd1, 32'hFFFF_FFFF, 0, 20, -1, 0);
    check_eq("bad_latency", lat, 32'd0);
    check_eq("bad_err", {31'h0, rsp_err_s}, 32'h1);
    check_eq("bad_no_strobe", n_rd + wr_param.size(), 32'd0);

    // Boot with busy stuck high: 16 guard/wait cycles (n=2..17) then error at n=18
    run_cmd(2'd2, 3'd0, 2'd0, 32'hC000_2000, 1000, 60, -1, 0);
    check_eq("tmo_latency", lat, 32'd18);
    check_eq("tmo_err", {31'h0, rsp_err_s}, 32'h1);
    check_eq("tmo_no_reconfig", {31'h0, rsu_reconfig}, 32'h0);
    check_eq("tmo_rsp_data", bus.rsp_data, 32'h00AB_CDE0);
    check_eq("tmo_page_param", {29'h0, wr_param[0]}, 32'd4);
    check_eq("tmo_page_data", wr_data[0], 32'h0000_2000);
    check_eq("tmo_wr_count", wr_param.size(), 32'd1);

    // Next command after a timeout is accepted normally
    run_cmd(2'd1, 3'd1, 2'd0, 32'hA5A5_0001, 0, 40, -1, 0);
    check_eq("post_tmo_latency", lat, 32'd5);
    check_eq("post_tmo_err", {31'h0, rsp_err_s}, 32'h0);

    // clk_en low for three cycles during the strobe: strobe stretches to 4 cycles
    run_cmd(2'd1, 3'd6, 2'd0, 32'h0000_0055, 0, 40, 1, 3);
    check_eq("frz_strobe_cycles", wr_param.size(), 32'd4);
    check_eq("frz_latency", lat, 32'd8);
    check_eq("frz_err", {31'h0, rsp_err_s}, 32'h0);

    // Watchdog kick: any 32 enabled cycles hold exactly 32/KickDiv pulses
    cnt_a = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (rsu_timer) cnt_a++;
    end
`ifdef RSU_WDT_EN
    check_eq("timer_pulses", cnt_a, 32'd4);
`else
    check_eq("timer_pulses", cnt_a, 32'd0);
`endif

    // Async reset while waiting on busy
    run_cmd(2'd0, 3'd3, 2'd1, 32'h0, 1000, 6, -1, 0);
    rsu_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rd", {31'h0, rsu_rd}, 32'h0);
    check_eq("arst_param", {29'h0, rsu_param}, 32'h0);
    check_eq("arst_src", {30'h0, rsu_src}, 32'h0);
    check_eq("arst_rsp_data", bus.rsp_data, 32'h0);
    check_eq("arst_ready", {31'h0, bus.cmd_ready}, 32'h0);
    #2;
    rst_n = 1'b1;
    rsu_busy = 1'b0;
    #1;
    check_eq("arst_release_ready", {31'h0, bus.cmd_ready}, 32'h0);
    step();
    step();
    check_eq("arst_ready_after", {31'h0, bus.cmd_ready}, 32'h1);

    // Boot image: page write (plus watchdog writes when enabled), then sticky reconfig
    run_cmd(2'd2, 3'd0, 2'd0, 32'hC000_2000, 0, 80, -1, 0);
    check_eq("boot_reconfig", {31'h0, saw_reconfig}, 32'h1);
    check_eq("boot_no_rsp", {31'h0, saw_rsp}, 32'h0);
    check_eq("boot_page_param", {29'h0, wr_param[0]}, 32'd4);
    check_eq("boot_page_data", wr_data[0], 32'h0000_2000);
`ifdef RSU_WDT_EN
    check_eq("boot_wr_count", wr_param.size(), 32'd3);
    check_eq("boot_latency", lat, 32'd15);
    check_eq("boot_wdtval_param", {29'h0, wr_param[1]}, 32'd2);
    check_eq("boot_wdtval_data", wr_data[1], 32'hFFFF_F000);
    check_eq("boot_wdten_param", {29'h0, wr_param[2]}, 32'd3);
    check_eq("boot_wdten_data", wr_data[2], 32'h0000_0001);
`else
    check_eq("boot_wr_count", wr_param.size(), 32'd1);
    check_eq("boot_latency", lat, 32'd5);
`endif
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd1;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (rsu_reconfig) cnt_a++;
      if (bus.cmd_ready || bus.rsp_valid) cnt_b++;
      if (rsu_timer) cnt_c++;
    end
    bus.cmd_valid = 1'b0;
    check_eq("reconfig_sticky", cnt_a, 32'd16);
    check_eq("reconfig_locked", cnt_b, 32'd0);
    check_eq("reconfig_no_timer", cnt_c, 32'd0);

    rst_n = 1'b0;
    #1;
    check_eq("reconfig_cleared", {31'h0, rsu_reconfig}, 32'h0);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
